demo_de0_sys_st_latency_adapter: RTL and testbench
==================================================

DEMO_DE0_SYS_ST_LATENCY_ADAPTER -- requirements
Module: demo_de0_sys_st_latency_adapter

Interface
REQ-001 Parameter DATA_W, default 32: payload width in bits, range 1..256.
REQ-002 Parameter DEPTH, default 8: FIFO entries, power of two, range 2..64, SHALL be greater than IN_READY_LATENCY+1.
REQ-003 Parameter IN_READY_LATENCY, default 0: upstream ready latency in cycles, range 0..3.
REQ-004 Parameter OUT_READY_LATENCY, default 0: downstream ready latency in cycles, range 0..3.
REQ-005 Parameter USE_PACKETS, default 0: when 1, sop/eop travel with each beat; when 0, sop/eop inputs are ignored and outputs are tied 0.
REQ-006 clk  input  1  single clock; every register is rising-edge clocked.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 in_ready  output  1  upstream ready, subject to IN_READY_LATENCY.
REQ-009 in_valid  input  1  upstream beat valid.
REQ-010 in_data  input  DATA_W  upstream payload.
REQ-011 in_startofpacket, in_endofpacket  input  1 each  packet delimiters.
REQ-012 out_ready  input  1  downstream ready, subject to OUT_READY_LATENCY.
REQ-013 out_valid  output  1  downstream beat valid.
REQ-014 out_data  output  DATA_W  downstream payload.
REQ-015 out_startofpacket, out_endofpacket  output  1 each  packet delimiters.
REQ-016 fill_level  output  clog2(DEPTH)+1  number of stored entries.
REQ-017 overflow  output  1  sticky error flag.

Function
REQ-018 Storage SHALL be a circular FIFO of DEPTH entries, each {sop, eop, data}, with write and read pointers wrapping modulo DEPTH.
REQ-019 Input acceptance: a beat is written at cycle t iff in_valid(t)=1 and in_ready(t-IN_READY_LATENCY)=1; for latency 0 this is the same-cycle handshake.
REQ-020 Credit rule: in_ready(t) = (fill_level(t) + number of cycles in [t-IN_READY_LATENCY, t-1] with in_ready=1) < DEPTH; in_ready is registered history plus combinational compare and is conservative.
REQ-021 Output, OUT_READY_LATENCY=0: out_valid = (fill_level != 0); a beat pops when out_valid and out_ready are both 1.
REQ-022 Output, OUT_READY_LATENCY=L>0: out_valid(t) = out_ready(t-L) and (fill_level(t) != 0); every beat with out_valid=1 pops, and out_ready at t is not examined for that pop.
REQ-023 out_data and the sop/eop outputs SHALL be a combinational read of the head entry, giving zero-cycle first-word fall-through; values are don't-care while out_valid=0.
REQ-024 Latency from write to earliest out_valid SHALL be 1 cycle, because the entry becomes visible after the write edge.
REQ-025 fill_level updates each edge by +1 on write only, -1 on pop only, and 0 on simultaneous write and pop or no event.
REQ-026 A write attempted while fill_level=DEPTH and no pop occurs in the same cycle SHALL drop the beat, leave pointers unchanged, and set overflow=1 until reset.
REQ-027 A simultaneous write and pop at fill_level=DEPTH SHALL be accepted: the beat is stored and fill_level stays at DEPTH.
REQ-028 A pop is never issued with fill_level=0, so the empty FIFO cannot underflow.
REQ-029 Beat order and payload bits SHALL be preserved exactly; the block SHALL NOT reorder or merge beats.

Reset
REQ-030 Assertion of reset_n=0 SHALL immediately clear pointers, fill_level, overflow and the ready history registers.
REQ-031 While reset_n=0: out_valid=0, in_ready=0, fill_level=0 and overflow=0.
REQ-032 in_ready SHALL rise on the first clk edge after reset_n deassertion; beats in flight when reset is applied mid-transfer are discarded.

Verification
REQ-033 DEPTH=8, latencies 0: write 8 beats with out_ready=0 -> fill_level=8, in_ready=0; raise out_ready -> 8 beats out in order, fill_level=0.
REQ-034 IN_READY_LATENCY=2, DEPTH=8, in_valid driven exactly 2 cycles after every in_ready=1, out_ready=0 -> fill_level reaches at most 8 and overflow stays 0.
REQ-035 OUT_READY_LATENCY=1, FIFO holding 3 beats, out_ready pulsed high at t=5 only -> out_valid=1 at t=6 only, and exactly one beat pops.
REQ-036 fill_level=8 with in_valid forced outside the credit rule and no pop -> beat dropped, overflow=1, FIFO contents unchanged.
REQ-037 USE_PACKETS=1, 3-beat packet (sop on beat 0, eop on beat 2) with random out_ready -> delimiters emerge on the same beats.
REQ-038 reset_n pulsed low with 5 beats stored -> out_valid=0 and fill_level=0 asynchronously, and in_ready=1 on the first edge after release.

Source files
------------

// File: rtl/demo_de0_sys_st_latency_adapter.sv
// demo_de0_sys_st_latency_adapter
// Streaming FIFO that bridges an upstream port with IN_READY_LATENCY to a
// downstream port with OUT_READY_LATENCY. Storage is a circular buffer of
// {sop, eop, data} entries with first-word fall-through on the read side.
//
// Handshake semantics (both ports):
//   Upstream:   a beat transfers in cycle t when in_valid(t)=1 and
//               in_ready(t-IN_READY_LATENCY)=1 (same cycle when latency is 0).
//               in_ready is a conservative credit: stored entries plus the
//               ready cycles still in flight must stay below DEPTH.
//   Downstream: latency 0 -> a beat pops when out_valid && out_ready.
//               latency L -> out_valid(t) = out_ready(t-L) && !empty, and
//               every cycle with out_valid=1 pops a beat.
// A beat presented while full with no pop is dropped and sets the sticky
// overflow flag; a beat presented while full in the same cycle as a pop is
// stored, so the slot freed by the pop is reused immediately.
module demo_de0_sys_st_latency_adapter #(
   parameter int DATA_W            = 32,
   parameter int DEPTH             = 8,
   parameter int IN_READY_LATENCY  = 0,
   parameter int OUT_READY_LATENCY = 0,
   parameter int USE_PACKETS       = 0
) (
   input  logic                     clk,
   input  logic                     reset_n,
   output logic                     in_ready,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     in_startofpacket,
   input  logic                     in_endofpacket,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_startofpacket,
   output logic                     out_endofpacket,
   output logic [$clog2(DEPTH):0]   fill_level,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = AW + 1;
   localparam int EW = DATA_W + 2;
   // Credit sum holds fill (up to DEPTH) plus up to 3 in-flight ready cycles.
   localparam int CW = AW + 3;

   // Storage and pointers
   logic [EW-1:0]  r_mem [DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [FW-1:0]  r_fill;
   logic           r_overflow;
   // Goes high on the first edge after reset release; holds in_ready low
   // until then so the upstream never sees ready during reset.
   logic           r_run;

   // Control wires
   logic           w_accept_ok;
   logic [CW-1:0]  w_pending;
   logic           w_pop;
   logic           w_full;
   logic           w_not_empty;
   logic           w_room;
   logic           w_wr_en;
   logic           w_ovf_set;
   logic           w_pkt;
   logic           w_sop_in;
   logic           w_eop_in;
   logic [EW-1:0]  w_head;

   assign w_pkt       = (USE_PACKETS != 0);
   assign w_sop_in    = w_pkt & in_startofpacket;
   assign w_eop_in    = w_pkt & in_endofpacket;
   assign w_full      = (r_fill == FW'(DEPTH));
   assign w_not_empty = (r_fill != '0);

   // Upstream credit: stored entries plus ready cycles not yet answered.
   assign in_ready = r_run && ((CW'(r_fill) + w_pending) < CW'(DEPTH));

   // ------------------------------------------------------------------
   // Upstream ready history
   // ------------------------------------------------------------------
   generate
      if (IN_READY_LATENCY == 0) begin : g_irl0
         assign w_accept_ok = in_ready;
         assign w_pending   = '0;
      end else begin : g_irl
         // bit 0 is in_ready one cycle ago, bit L-1 is L cycles ago
         logic [IN_READY_LATENCY-1:0] r_ir_hist;

         // Shift the in_ready history by one cycle each edge.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_ir_hist <= '0;
            end else begin
               r_ir_hist[0] <= in_ready;
               for (int i = 1; i < IN_READY_LATENCY; i++) begin
                  r_ir_hist[i] <= r_ir_hist[i-1];
               end
            end
         end

         // Count ready cycles still in flight (their beats may yet arrive).
         always_comb begin
            w_pending = '0;
            for (int i = 0; i < IN_READY_LATENCY; i++) begin
               w_pending = w_pending + CW'(r_ir_hist[i]);
            end
         end

         assign w_accept_ok = r_ir_hist[IN_READY_LATENCY-1];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Downstream ready history and pop decision
   // ------------------------------------------------------------------
   generate
      if (OUT_READY_LATENCY == 0) begin : g_orl0
         assign out_valid = w_not_empty;
         assign w_pop     = w_not_empty && out_ready;
      end else begin : g_orl
         logic [OUT_READY_LATENCY-1:0] r_or_hist;

         // Delay out_ready by OUT_READY_LATENCY cycles.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_or_hist <= '0;
            end else begin
               r_or_hist[0] <= out_ready;
               for (int i = 1; i < OUT_READY_LATENCY; i++) begin
                  r_or_hist[i] <= r_or_hist[i-1];
               end
            end
         end

         // The sink committed to accept this cycle L cycles ago.
         assign out_valid = r_or_hist[OUT_READY_LATENCY-1] && w_not_empty;
         assign w_pop     = out_valid;
      end
   endgenerate

   // Write/overflow decision. A full FIFO with a pop in the same cycle
   // takes the beat even though the conservative credit had ready low.
   always_comb begin
      w_room    = 1'b0;
      w_wr_en   = 1'b0;
      w_ovf_set = 1'b0;
      w_room    = !w_full || w_pop;
      w_wr_en   = in_valid && w_room && (w_accept_ok || w_full);
      w_ovf_set = in_valid && w_full && !w_pop;
   end

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   // Entry write; contents need no reset since pointers define validity.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= {w_sop_in, w_eop_in, in_data};
      end
   end

   // Pointer, fill and sticky overflow bookkeeping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fill     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_wr_en, w_pop})
            2'b10:   r_fill <= r_fill + FW'(1);
            2'b01:   r_fill <= r_fill - FW'(1);
            default: r_fill <= r_fill;
         endcase
         if (w_ovf_set) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Run flag: released one edge after reset deassertion.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_run <= 1'b0;
      end else begin
         r_run <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Outputs: combinational read of the head entry
   // ------------------------------------------------------------------
   assign w_head            = r_mem[r_rd_ptr];
   assign out_data          = w_head[DATA_W-1:0];
   assign out_startofpacket = w_pkt & w_head[DATA_W+1];
   assign out_endofpacket   = w_pkt & w_head[DATA_W];
   assign fill_level        = r_fill;
   assign overflow          = r_overflow;

endmodule

// File: tb/tb_demo_de0_sys_st_latency_adapter.sv
// Testbench for demo_de0_sys_st_latency_adapter. Three instances share clock
// and reset: A (latencies 0, packets on), B (in latency 2, packets off),
// C (out latency 1). Inputs are driven on the falling edge and outputs are
// sampled 1 time unit later, well away from the rising edge.
module tb_demo_de0_sys_st_latency_adapter;

   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst_n;

   int n_vec = 0;
   int n_err = 0;

   // Instance A signals
   logic          a_in_ready, a_in_valid, a_sop, a_eop, a_out_ready;
   logic          a_out_valid, a_out_sop, a_out_eop, a_overflow;
   logic [DW-1:0] a_in_data, a_out_data;
   logic [3:0]    a_fill;
   // Instance B signals
   logic          b_in_ready, b_in_valid, b_sop, b_eop, b_out_ready;
   logic          b_out_valid, b_out_sop, b_out_eop, b_overflow;
   logic [DW-1:0] b_in_data, b_out_data;
   logic [3:0]    b_fill;
   // Instance C signals
   logic          c_in_ready, c_in_valid, c_sop, c_eop, c_out_ready;
   logic          c_out_valid, c_out_sop, c_out_eop, c_overflow;
   logic [DW-1:0] c_in_data, c_out_data;
   logic [3:0]    c_fill;

   demo_de0_sys_st_latency_adapter #(
      .DATA_W(DW), .DEPTH(8), .IN_READY_LATENCY(0), .OUT_READY_LATENCY(0), .USE_PACKETS(1)
   ) u_dut_a (
      .clk(clk), .reset_n(rst_n),
      .in_ready(a_in_ready), .in_valid(a_in_valid), .in_data(a_in_data),
      .in_startofpacket(a_sop), .in_endofpacket(a_eop),
      .out_ready(a_out_ready), .out_valid(a_out_valid), .out_data(a_out_data),
      .out_startofpacket(a_out_sop), .out_endofpacket(a_out_eop),
      .fill_level(a_fill), .overflow(a_overflow)
   );

   demo_de0_sys_st_latency_adapter #(
      .DATA_W(DW), .DEPTH(8), .IN_READY_LATENCY(2), .OUT_READY_LATENCY(0), .USE_PACKETS(0)
   ) u_dut_b (
      .clk(clk), .reset_n(rst_n),
      .in_ready(b_in_ready), .in_valid(b_in_valid), .in_data(b_in_data),
      .in_startofpacket(b_sop), .in_endofpacket(b_eop),
      .out_ready(b_out_ready), .out_valid(b_out_valid), .out_data(b_out_data),
      .out_startofpacket(b_out_sop), .out_endofpacket(b_out_eop),
      .fill_level(b_fill), .overflow(b_overflow)
   );

   demo_de0_sys_st_latency_adapter #(
      .DATA_W(DW), .DEPTH(8), .IN_READY_LATENCY(0), .OUT_READY_LATENCY(1), .USE_PACKETS(0)
   ) u_dut_c (
      .clk(clk), .reset_n(rst_n),
      .in_ready(c_in_ready), .in_valid(c_in_valid), .in_data(c_in_data),
      .in_startofpacket(c_sop), .in_endofpacket(c_eop),
      .out_ready(c_out_ready), .out_valid(c_out_valid), .out_data(c_out_data),
      .out_startofpacket(c_out_sop), .out_endofpacket(c_out_eop),
      .fill_level(c_fill), .overflow(c_overflow)
   );

   // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Reset values while reset_n=0, then in_ready rising on the first edge.
   task automatic test_reset();
      rst_n = 1'b0;
      a_in_valid = 0; a_in_data = '0; a_sop = 0; a_eop = 0; a_out_ready = 0;
      b_in_valid = 0; b_in_data = '0; b_sop = 0; b_eop = 0; b_out_ready = 0;
      c_in_valid = 0; c_in_data = '0; c_sop = 0; c_eop = 0; c_out_ready = 0;
      #2;
      n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
      n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", a_in_ready); end
      n_vec++; if (a_fill !== 4'd0) begin n_err++; $display("FAIL reset_fill got %0d want 0", a_fill); end
      n_vec++; if (a_overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", a_overflow); end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL release_ready_early got %b want 0", a_in_ready); end
      @(negedge clk); #1;
      n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL release_ready_a got %b want 1", a_in_ready); end
      n_vec++; if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL release_ready_b got %b want 1", b_in_ready); end
      n_vec++; if (c_in_ready !== 1'b1) begin n_err++; $display("FAIL release_ready_c got %b want 1", c_in_ready); end
   endtask

   // Fill 8 beats with out_ready low, then drain in order.
   task automatic test_fill_drain();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         a_in_valid = 1'b1; a_in_data = 8'(8'hA0 + i);
         #1;
         n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready[%0d] got %b want 1", i, a_in_ready); end
      end
      @(negedge clk);
      a_in_valid = 1'b0;
      #1;
      n_vec++; if (a_fill !== 4'd8) begin n_err++; $display("FAIL full_level got %0d want 8", a_fill); end
      n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %b want 0", a_in_ready); end
      n_vec++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL full_valid got %b want 1", a_out_valid); end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         a_out_ready = 1'b1;
         #1;
         n_vec++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d] got %b want 1", i, a_out_valid); end
         n_vec++; if (a_out_data !== 8'(8'hA0 + i)) begin n_err++; $display("FAIL drain_data[%0d] got %h want %h", i, a_out_data, 8'(8'hA0 + i)); end
      end
      @(negedge clk);
      a_out_ready = 1'b0;
      #1;
      n_vec++; if (a_fill !== 4'd0) begin n_err++; $display("FAIL drained_level got %0d want 0", a_fill); end
      n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL drained_valid got %b want 0", a_out_valid); end
   endtask

   // Write against a full FIFO without a pop: beat dropped, overflow sticky.
   task automatic test_overflow();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         a_in_valid = 1'b1; a_in_data = 8'(8'hB0 + i);
      end
      @(negedge clk);
      a_in_valid = 1'b1; a_in_data = 8'hEE; a_out_ready = 1'b0;
      #1;
      n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL ovf_ready got %b want 0", a_in_ready); end
      @(negedge clk);
      a_in_valid = 1'b0;
      #1;
      n_vec++; if (a_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", a_overflow); end
      n_vec++; if (a_fill !== 4'd8) begin n_err++; $display("FAIL ovf_level got %0d want 8", a_fill); end
   endtask

   // Write and pop together at full: beat stored, level stays 8, order kept.
   task automatic test_full_passthrough();
      @(negedge clk);
      a_in_valid = 1'b1; a_in_data = 8'hCC; a_out_ready = 1'b1;
      #1;
      n_vec++; if (a_out_data !== 8'hB0) begin n_err++; $display("FAIL pass_head got %h want b0", a_out_data); end
      @(negedge clk);
      a_in_valid = 1'b0; a_out_ready = 1'b0;
      #1;
      n_vec++; if (a_fill !== 4'd8) begin n_err++; $display("FAIL pass_level got %0d want 8", a_fill); end
      for (int i = 0; i < 8; i++) begin
         logic [DW-1:0] exp_d;
         exp_d = (i < 7) ? 8'(8'hB1 + i) : 8'hCC;
         @(negedge clk);
         a_out_ready = 1'b1;
         #1;
         n_vec++; if (a_out_data !== exp_d) begin n_err++; $display("FAIL pass_data[%0d] got %h want %h", i, a_out_data, exp_d); end
      end
      @(negedge clk);
      a_out_ready = 1'b0;
      #1;
      n_vec++; if (a_fill !== 4'd0) begin n_err++; $display("FAIL pass_empty got %0d want 0", a_fill); end
      n_vec++; if (a_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", a_overflow); end
   endtask

   // 3-beat packet with random downstream ready; delimiters stay on beats.
   task automatic test_packets();
      int sent;
      int rcv;
      sent = 0;
      rcv  = 0;
      for (int cyc = 0; cyc < 40 && rcv < 3; cyc++) begin
         @(negedge clk);
         a_in_valid  = (sent < 3);
         a_in_data   = 8'(8'h51 + sent);
         a_sop       = (sent == 0);
         a_eop       = (sent == 2);
         a_out_ready = (cyc >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
         #1;
         if (a_out_valid && a_out_ready) begin
            n_vec++; if (a_out_data !== 8'(8'h51 + rcv)) begin n_err++; $display("FAIL pkt_data[%0d] got %h want %h", rcv, a_out_data, 8'(8'h51 + rcv)); end
            n_vec++; if (a_out_sop !== (rcv == 0)) begin n_err++; $display("FAIL pkt_sop[%0d] got %b want %b", rcv, a_out_sop, (rcv == 0)); end
            n_vec++; if (a_out_eop !== (rcv == 2)) begin n_err++; $display("FAIL pkt_eop[%0d] got %b want %b", rcv, a_out_eop, (rcv == 2)); end
            rcv++;
         end
         if (sent < 3) sent++;
      end
      @(negedge clk);
      a_in_valid = 0; a_sop = 0; a_eop = 0; a_out_ready = 0;
      #1;
      n_vec++; if (rcv !== 3) begin n_err++; $display("FAIL pkt_count got %0d want 3", rcv); end
      n_vec++; if (a_fill !== 4'd0) begin n_err++; $display("FAIL pkt_empty got %0d want 0", a_fill); end
   endtask

   // In latency 2: upstream answers every ready exactly 2 cycles later.
   task automatic test_in_latency();
      int   sent;
      logic d1;
      logic d2;
      sent = 0; d1 = 1'b0; d2 = 1'b0;
      for (int cyc = 0; cyc < 25; cyc++) begin
         @(negedge clk);
         b_in_valid = d2;
         b_in_data  = 8'(sent);
         b_sop      = 1'b1;
         d2 = d1;
         d1 = b_in_ready;
         if (b_in_valid) sent++;
         #1;
         n_vec++; if (b_fill > 4'd8) begin n_err++; $display("FAIL irl_level[%0d] got %0d want <=8", cyc, b_fill); end
      end
      @(negedge clk);
      b_in_valid = 1'b0;
      #1;
      n_vec++; if (b_fill !== 4'd8) begin n_err++; $display("FAIL irl_final got %0d want 8", b_fill); end
      n_vec++; if (sent !== 8) begin n_err++; $display("FAIL irl_sent got %0d want 8", sent); end
      n_vec++; if (b_overflow !== 1'b0) begin n_err++; $display("FAIL irl_overflow got %b want 0", b_overflow); end
      n_vec++; if (b_in_ready !== 1'b0) begin n_err++; $display("FAIL irl_ready got %b want 0", b_in_ready); end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         b_out_ready = 1'b1;
         #1;
         n_vec++; if (b_out_data !== 8'(i)) begin n_err++; $display("FAIL irl_data[%0d] got %h want %h", i, b_out_data, 8'(i)); end
         n_vec++; if (b_out_sop !== 1'b0) begin n_err++; $display("FAIL irl_sop_tied[%0d] got %b want 0", i, b_out_sop); end
      end
      @(negedge clk);
      b_out_ready = 1'b0; b_sop = 1'b0;
      #1;
      n_vec++; if (b_fill !== 4'd0) begin n_err++; $display("FAIL irl_empty got %0d want 0", b_fill); end
   endtask

   // Out latency 1: one-cycle out_ready pulse yields one valid cycle one later.
   task automatic test_out_latency();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         c_in_valid = 1'b1; c_in_data = 8'(8'h70 + i);
      end
      @(negedge clk);
      c_in_valid = 1'b0;
      @(negedge clk); #1;
      n_vec++; if (c_fill !== 4'd3) begin n_err++; $display("FAIL orl_level got %0d want 3", c_fill); end
      n_vec++; if (c_out_valid !== 1'b0) begin n_err++; $display("FAIL orl_idle_valid got %b want 0", c_out_valid); end
      for (int p = 0; p < 2; p++) begin
         @(negedge clk);
         c_out_ready = 1'b1;
         #1;
         n_vec++; if (c_out_valid !== 1'b0) begin n_err++; $display("FAIL orl_pulse_valid[%0d] got %b want 0", p, c_out_valid); end
         @(negedge clk);
         c_out_ready = 1'b0;
         #1;
         n_vec++; if (c_out_valid !== 1'b1) begin n_err++; $display("FAIL orl_resp_valid[%0d] got %b want 1", p, c_out_valid); end
         n_vec++; if (c_out_data !== 8'(8'h70 + p)) begin n_err++; $display("FAIL orl_data[%0d] got %h want %h", p, c_out_data, 8'(8'h70 + p)); end
         @(negedge clk); #1;
         n_vec++; if (c_out_valid !== 1'b0) begin n_err++; $display("FAIL orl_after_valid[%0d] got %b want 0", p, c_out_valid); end
         n_vec++; if (c_fill !== 4'(2 - p)) begin n_err++; $display("FAIL orl_after_level[%0d] got %0d want %0d", p, c_fill, 2 - p); end
      end
   endtask

   // Mid-cycle reset with 5 beats stored clears everything asynchronously.
   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         a_in_valid = 1'b1; a_in_data = 8'(8'hD0 + i);
      end
      @(negedge clk);
      a_in_valid = 1'b0;
      #1;
      n_vec++; if (a_fill !== 4'd5) begin n_err++; $display("FAIL mid_level got %0d want 5", a_fill); end
      #1;
      rst_n = 1'b0;
      #1;
      n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got %b want 0", a_out_valid); end
      n_vec++; if (a_fill !== 4'd0) begin n_err++; $display("FAIL mid_fill got %0d want 0", a_fill); end
      n_vec++; if (a_overflow !== 1'b0) begin n_err++; $display("FAIL mid_overflow got %b want 0", a_overflow); end
      n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL mid_ready got %b want 0", a_in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL mid_release_early got %b want 0", a_in_ready); end
      @(negedge clk); #1;
      n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL mid_release_ready got %b want 1", a_in_ready); end
      n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL mid_release_valid got %b want 0", a_out_valid); end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow();
      test_full_passthrough();
      test_packets();
      test_in_latency();
      test_out_latency();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
